// File: rtl/aurora_sup_pkg.sv
// Shared types and constants for the Aurora link supervisor.
package aurora_sup_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 8;

  typedef enum logic [STATE_W-1:0] {
    GT_RST  = 3'd0,
    SYS_RST = 3'd1,
    WAIT_UP = 3'd2,
    LINKED  = 3'd3,
    FAIL    = 3'd4
  } sup_state_e;

  // Largest of three phase lengths, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aurora_bit_sync.sv
// Two-flop synchroniser for one asynchronous level into the init clock domain.
module aurora_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages clear on reset so synced outputs start low.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aurora_link_supervisor.sv
// Reset sequencer and link watchdog for an Aurora 8b10b channel group.
module aurora_link_supervisor
  import aurora_sup_pkg::*;
#(
  parameter int SFP_CHANNEL     = 2,
  parameter int GT_RESET_CYCLES = 512,
  parameter int RESET_CYCLES    = 128,
  parameter int UP_TIMEOUT      = 1048576,
  parameter int DOWN_FILTER     = 16,
  parameter int MAX_RETRY       = 7,
  parameter int CNT_W           = 16
) (
  input  logic                         init_clk_in,
  input  logic                         reset,
  input  logic [SFP_CHANNEL-1:0]       chan_en,
  input  logic [SFP_CHANNEL-1:0]       channel_up,
  input  logic [SFP_CHANNEL-1:0]       hard_err,
  input  logic                         force_reset,
  input  logic                         retry_req,
  output logic                         aurora_reset,
  output logic                         aurora_gt_reset,
  output logic                         link_ok,
  output logic                         link_fail,
  output logic [STATE_W-1:0]           state,
  output logic [RETRY_W-1:0]           retry_cnt,
  output logic [SFP_CHANNEL*CNT_W-1:0] drop_cnt,
  output logic [SFP_CHANNEL-1:0]       chan_up_sync
);

  localparam int TMAX = max3(GT_RESET_CYCLES, RESET_CYCLES, UP_TIMEOUT);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int DW   = $clog2(DOWN_FILTER + 1);

  localparam logic [TW-1:0]      GT_LAST = TW'(GT_RESET_CYCLES - 1);
  localparam logic [TW-1:0]      RS_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0]      UP_LAST = TW'(UP_TIMEOUT - 1);
  localparam logic [DW-1:0]      DN_LAST = DW'(DOWN_FILTER - 1);
  localparam logic [RETRY_W-1:0] RT_MAX  = RETRY_W'(MAX_RETRY);

  logic [SFP_CHANNEL-1:0] up_s, err_s;

  for (genvar i = 0; i < SFP_CHANNEL; i++) begin : g_sync
    aurora_bit_sync u_up  (.clk(init_clk_in), .reset(reset), .d(channel_up[i]), .q(up_s[i]));
    aurora_bit_sync u_err (.clk(init_clk_in), .reset(reset), .d(hard_err[i]),   .q(err_s[i]));
  end

  sup_state_e                        st_q, st_d;
  logic [TW-1:0]                     timer_q;
  logic [DW-1:0]                     dn_q;
  logic [RETRY_W-1:0]                retry_q, retry_d;
  logic [SFP_CHANNEL-1:0]            inc_mask;
  logic [SFP_CHANNEL-1:0][CNT_W-1:0] drop_q;
  logic                              all_up, any_err, filt_drop, clr_timer;

  // Disabled channels count as up and never flag errors.
  assign all_up    = &(up_s | ~chan_en);
  assign any_err   = |(err_s & chan_en);
  assign filt_drop = !all_up && (dn_q == DN_LAST);

  // Next state, retry bookkeeping and which drop counters to bump.
  always_comb begin
    st_d     = st_q;
    retry_d  = retry_q;
    inc_mask = '0;
    if (force_reset) begin
      st_d    = GT_RST;
      retry_d = '0;
    end else if (st_q == FAIL && retry_req) begin
      st_d    = GT_RST;
      retry_d = '0;
    end else begin
      unique case (st_q)
        GT_RST:  if (timer_q == GT_LAST) st_d = SYS_RST;
        SYS_RST: if (timer_q == RS_LAST) st_d = WAIT_UP;
        WAIT_UP: begin
          if (all_up) begin
            st_d    = LINKED;
            retry_d = '0;
          end else if (timer_q == UP_LAST) begin
            retry_d = (&retry_q) ? retry_q : retry_q + RETRY_W'(1);
            st_d    = (MAX_RETRY != 0 && retry_d == RT_MAX) ? FAIL : GT_RST;
          end
        end
        LINKED: begin
          if (filt_drop || any_err) begin
            st_d     = GT_RST;
            // A filtered drop blames the down channels; an error-only drop blames the flaggers.
            inc_mask = filt_drop ? (chan_en & ~up_s) : (chan_en & err_s);
          end
        end
        default: ;
      endcase
    end
  end

  // force_reset restarts the sequence even when already in GT_RST.
  assign clr_timer = (st_d != st_q) || force_reset;

  // State, timer, down filter, retry count and registered output decode.
  always_ff @(posedge init_clk_in) begin
    if (reset) begin
      st_q            <= GT_RST;
      timer_q         <= '0;
      dn_q            <= '0;
      retry_q         <= '0;
      aurora_gt_reset <= 1'b1;
      aurora_reset    <= 1'b1;
      link_ok         <= 1'b0;
      link_fail       <= 1'b0;
    end else begin
      st_q    <= st_d;
      retry_q <= retry_d;
      if (clr_timer || st_q == LINKED || st_q == FAIL) timer_q <= '0;
      else                                              timer_q <= timer_q + TW'(1);
      if (st_q == LINKED && st_d == LINKED && !all_up) dn_q <= dn_q + DW'(1);
      else                                             dn_q <= '0;
      aurora_gt_reset <= (st_d == GT_RST) || (st_d == FAIL);
      aurora_reset    <= (st_d == GT_RST) || (st_d == SYS_RST) || (st_d == FAIL);
      link_ok         <= (st_d == LINKED);
      link_fail       <= (st_d == FAIL);
    end
  end

  for (genvar i = 0; i < SFP_CHANNEL; i++) begin : g_drop
    // Per-channel saturating drop counter.
    always_ff @(posedge init_clk_in) begin
      if (reset)                         drop_q[i] <= '0;
      else if (inc_mask[i] && !(&drop_q[i])) drop_q[i] <= drop_q[i] + CNT_W'(1);
    end
  end

  assign state        = st_q;
  assign retry_cnt    = retry_q;
  assign drop_cnt     = drop_q;
  assign chan_up_sync = up_s;

endmodule
